// File: rtl/bitrev_reorder_buf.sv
// rtl/bitrev_reorder_buf.sv - ping-pong frame buffer emitting samples in bit-reversed index order
module bitrev_reorder_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_N     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int N = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};

    // Bank select is the top address bit: bank b occupies [b*N, b*N+N-1]
    logic [DATA_WIDTH-1:0] mem [0:2*N-1];

    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wsel;
    logic              rsel;
    logic [LOG2_N-1:0] wcnt;
    logic [LOG2_N-1:0] rcnt;
    logic [LOG2_N-1:0] rcnt_rev;
    logic              in_acc;
    logic              out_acc;

    assign in_ready  = !full[wsel];
    assign out_valid = full[rsel];
    assign out_last  = out_valid && (rcnt == CNT_LAST);
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;

    always_comb begin
        rcnt_rev = '0;
        for (int i = 0; i < LOG2_N; i++) begin
            rcnt_rev[i] = rcnt[LOG2_N-1-i];
        end
    end

    // The read bank is never written while full, so this holds steady under backpressure
    assign out_data = mem[{rsel, rcnt_rev}];

    // Set and clear always address different banks, so both may apply together
    always_comb begin
        full_nxt = full;
        if (out_acc && (rcnt == CNT_LAST)) begin
            full_nxt[rsel] = 1'b0;
        end
        if (in_acc && (wcnt == CNT_LAST)) begin
            full_nxt[wsel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_acc) begin
            mem[{wsel, wcnt}] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
            wsel <= 1'b0;
            rsel <= 1'b0;
            wcnt <= '0;
            rcnt <= '0;
        end else begin
            full <= full_nxt;
            if (in_acc) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == CNT_LAST) begin
                    wsel <= !wsel;
                end
            end
            if (out_acc) begin
                rcnt <= rcnt + 1'b1;
                if (rcnt == CNT_LAST) begin
                    rsel <= !rsel;
                end
            end
        end
    end

endmodule
